// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronized input, mid-bit sampling,
// valid/ack output with frame error and overrun pulses.
module uart_rx #(
  parameter int BAUD = 9600,
  parameter int F    = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = F / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state, state_n;

  logic          rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data_n;
  logic          valid_n;
  logic          ferr_n;
  logic          ovr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data;
    valid_n = valid & ~ack;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shreg;
            valid_n = 1'b1;
            // an ack in this same cycle frees the slot: no overrun
            ovr_n   = valid & ~ack;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, corner sequences,
// and random frames against a frame-level behavioural model.
module tb_uart_rx;

  localparam int DV = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx, ack;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  logic       rx2, ack2;
  logic [7:0] data2;
  logic       valid2, ferr2, ovr2, busy2;

  uart_rx #(.BAUD(1), .F(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .ack(ack), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  uart_rx u_def (
    .clk(clk), .rst(rst), .rx(rx2), .data(data2), .valid(valid2),
    .ack(ack2), .frame_err(ferr2), .overrun(ovr2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int ferr_cnt = 0, ovr_cnt = 0, vrise_cnt = 0, rise_cyc = 0;
  int ferr2_cnt = 0;
  logic valid_q = 1'b0;
  bit busy_seen = 0;
  int n_vec = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (ferr2) ferr2_cnt++;
    if (valid && !valid_q) begin
      vrise_cnt++;
      rise_cyc = cyc;
    end
    valid_q = valid;
    if (busy) busy_seen = 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: run time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] b;
    bit         stop_ok;
    bit         ack_first;
    logic [7:0] exp_data;
    bit         exp_valid;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit stop,
                      input int ack_at, input int gap);
    int k;
    for (int c = 0; c < 10 * DV; c++) begin
      k = c / DV;
      if (k == 0) rx = 1'b0;
      else if (k == 9) rx = stop;
      else rx = b[k-1];
      ack = (c == ack_at);
      tick(1);
    end
    rx  = 1'b1;
    ack = 1'b0;
    tick(gap);
  endtask

  vec_t tbl[6];
  int f0, o0, v0, st;
  logic [7:0] exp_data, rb;
  bit exp_valid, ok, af;
  int ack_at, gap, eferr, eovr;

  initial begin
    tbl[0] = '{8'h35, 1, 0, 8'h35, 1, 0, 0};
    tbl[1] = '{8'hC3, 1, 1, 8'hC3, 1, 0, 0};
    tbl[2] = '{8'h5A, 1, 0, 8'h5A, 1, 0, 1};
    tbl[3] = '{8'h7E, 0, 1, 8'h5A, 0, 1, 0};
    tbl[4] = '{8'h00, 1, 0, 8'h00, 1, 0, 0};
    tbl[5] = '{8'hFF, 0, 0, 8'h00, 1, 1, 0};

    rst = 1'b1; rx = 1'b1; ack = 1'b0; rx2 = 1'b1; ack2 = 1'b0;
    tick(3);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    tick(3);

    // first frame: latency from rx fall to valid
    f0 = ferr_cnt; o0 = ovr_cnt;
    st = cyc;
    send(8'h35, 1, -1, 4);
    chk("lat", rise_cyc - st, 155);
    chk("d35", data, 8'h35);
    chk("v35", valid, 1);
    chk("f35", ferr_cnt - f0, 0);
    chk("o35", ovr_cnt - o0, 0);
    pulse_ack();
    chk("ack_clr", valid, 0);

    // start glitch
    f0 = ferr_cnt; busy_seen = 0;
    rx = 1'b0; tick(5);
    rx = 1'b1; tick(20);
    chk("gl_busy_seen", busy_seen, 1);
    chk("gl_busy", busy, 0);
    chk("gl_valid", valid, 0);
    chk("gl_ferr", ferr_cnt - f0, 0);

    // bad stop then stuck-low line
    f0 = ferr_cnt; v0 = vrise_cnt;
    send(8'hA5, 0, -1, 0);
    rx = 1'b0;
    tick(40);
    chk("wh_ferr", ferr_cnt - f0, 1);
    chk("wh_valid", valid, 0);
    chk("wh_data", data, 8'h35);
    chk("wh_busy", busy, 1);
    chk("wh_rise", vrise_cnt - v0, 0);
    rx = 1'b1; tick(4);
    chk("wh_idle", busy, 0);
    send(8'h12, 1, -1, 4);
    chk("d12", data, 8'h12);
    chk("v12", valid, 1);

    // back-to-back, unacked: overrun
    pulse_ack();
    o0 = ovr_cnt;
    send(8'h11, 1, -1, 0);
    send(8'h22, 1, -1, 4);
    chk("ov_cnt", ovr_cnt - o0, 1);
    chk("ov_data", data, 8'h22);
    chk("ov_valid", valid, 1);

    // ack in the completion cycle of the second frame
    pulse_ack();
    send(8'h11, 1, -1, 0);
    o0 = ovr_cnt;
    send(8'h22, 1, 154, 4);
    chk("ac_cnt", ovr_cnt - o0, 0);
    chk("ac_valid", valid, 1);
    chk("ac_data", data, 8'h22);

    // reset during data bit 4
    pulse_ack();
    f0 = ferr_cnt;
    rx = 1'b0; tick(DV);
    rx = 1'b1; tick(5 * DV - DV + 5);
    rst = 1'b1;
    tick(2);
    chk("mr_data", data, 8'h00);
    chk("mr_valid", valid, 0);
    chk("mr_busy", busy, 0);
    rst = 1'b0;
    tick(2);
    v0 = vrise_cnt;
    send(8'h0F, 1, -1, 4);
    chk("mr_d0f", data, 8'h0F);
    chk("mr_rise", vrise_cnt - v0, 1);
    chk("mr_ferr", ferr_cnt - f0, 0);

    // directed table
    pulse_ack();
    for (int i = 0; i < 6; i++) begin
      f0 = ferr_cnt; o0 = ovr_cnt;
      if (tbl[i].ack_first) pulse_ack();
      send(tbl[i].b, tbl[i].stop_ok, -1, 4);
      chk($sformatf("t%0d_data", i), data, tbl[i].exp_data);
      chk($sformatf("t%0d_valid", i), valid, tbl[i].exp_valid);
      chk($sformatf("t%0d_ferr", i), ferr_cnt - f0, tbl[i].exp_ferr);
      chk($sformatf("t%0d_ovr", i), ovr_cnt - o0, tbl[i].exp_ovr);
    end

    // random frames against frame-level model
    exp_data = 8'h00; exp_valid = 1;
    for (int i = 0; i < 30; i++) begin
      rb     = 8'($urandom);
      ok     = ($urandom_range(0, 7) != 0);
      af     = $urandom_range(0, 1) == 1;
      ack_at = ($urandom_range(0, 3) == 0) ? 154 : -1;
      gap    = ok ? $urandom_range(0, 3) : 4;
      eferr  = 0;
      eovr   = 0;
      if (af) exp_valid = 0;
      if (ok) begin
        eovr      = (exp_valid && ack_at != 154) ? 1 : 0;
        exp_data  = rb;
        exp_valid = 1;
      end else begin
        eferr = 1;
        if (ack_at == 154) exp_valid = 0;
      end
      f0 = ferr_cnt; o0 = ovr_cnt;
      if (af) pulse_ack();
      send(rb, ok, ack_at, gap);
      chk($sformatf("r%0d_data", i), data, exp_data);
      chk($sformatf("r%0d_valid", i), valid, exp_valid);
      chk($sformatf("r%0d_ferr", i), ferr_cnt - f0, eferr);
      chk($sformatf("r%0d_ovr", i), ovr_cnt - o0, eovr);
    end

    // default divider, line running 2% fast
    tick(4);
    for (int c = 0; c < 10 * 5104; c++) begin
      int k;
      k = c / 5104;
      if (k == 0) rx2 = 1'b0;
      else if (k == 9) rx2 = 1'b1;
      else rx2 = rb_const(k - 1);
      tick(1);
    end
    rx2 = 1'b1;
    tick(10);
    chk("def_data", data2, 8'h30);
    chk("def_valid", valid2, 1);
    chk("def_ferr", ferr2_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  function automatic logic rb_const(input int i);
    logic [7:0] v;
    v = 8'h30;
    return v[i];
  endfunction

endmodule
